spi_lcd_frame_rx: RTL and testbench

//  Front-end SPI slave of the display controller. Receives ST7735R-style 3-line 9-bit serial frames
//  (D/CX bit + 8-bit byte, MSB first) from the RasPi. Splits them into command bytes and RGB565 pixel words.

---
 rtl/lcd_ctrl_pkg.sv | 14 +
 rtl/cdc_sync_bit.sv | 16 +
 rtl/spi_lcd_frame_rx.sv | 90 +++++++++
 tb/tb_spi_lcd_frame_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: command codes, RGB565 geometry and serial frame shape shared by the LCD controller
package lcd_ctrl_pkg;
   localparam logic [7:0] CMD_NOP     = 8'h00;
   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_DISPOFF = 8'h28;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;
   localparam int RGB_R_W   = 5;
   localparam int RGB_G_W   = 6;
   localparam int RGB_B_W   = 5;
   localparam int PIXEL_W   = RGB_R_W + RGB_G_W + RGB_B_W;
   localparam int FRAME_LEN = 9;
   typedef enum logic [1:0] {RX_CMD, RX_PIX_HI, RX_PIX_LO} rx_state_t;
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: multi-flop synchroniser for one asynchronous bit with a selectable reset value
module cdc_sync_bit #(
   parameter int   DEPTH   = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   logic [DEPTH-1:0] chain;
   always_ff @(posedge i_clk)
      if (i_rst) chain <= {DEPTH{RST_VAL}};
      else       chain <= {chain[DEPTH-2:0], i_d};
   assign o_q = chain[DEPTH-1];
endmodule

// File: rtl/spi_lcd_frame_rx.sv
// spi_lcd_frame_rx: 3-line 9-bit SPI slave splitting frames into command bytes and RGB565 pixels
module spi_lcd_frame_rx
   import lcd_ctrl_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] CMD_RAMWR   = lcd_ctrl_pkg::CMD_RAMWR
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_spi_clk,
   input  logic               i_spi_cs,
   input  logic               i_spi_mosi,
   output logic [7:0]         o_inst_data,
   output logic               o_inst_en_pls,
   output logic [PIXEL_W-1:0] o_pixel_data,
   output logic               o_pixel_en_pls,
   output logic               o_frame_err_pls
);
   localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);
   logic sck_s, cs_s, mosi_s, sck_d, cs_d;
   logic sck_rise, cs_rise, cs_fall, bit_en, done, err_stb;
   logic inst_stb, pix_stb, hi_ld;
   logic [3:0] bit_cnt;
   logic [7:0] shift_reg, hi_byte;
   logic [8:0] frame;
   rx_state_t state, state_nx;
   // reset values idle the bus (SCK low, CS high) so leaving reset never fakes an edge
   cdc_sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_spi_clk), .o_q(sck_s));
   cdc_sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_spi_cs), .o_q(cs_s));
   cdc_sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_spi_mosi), .o_q(mosi_s));
   assign sck_rise = sck_s & ~sck_d;
   assign cs_rise  = cs_s & ~cs_d;
   assign cs_fall  = ~cs_s & cs_d;
   assign bit_en   = sck_rise & ~cs_s;
   assign frame    = {shift_reg, mosi_s};
   assign done     = bit_en && bit_cnt == LAST_BIT;
   assign err_stb  = cs_rise && bit_cnt != 4'd0;
   always_comb begin
      state_nx = state;
      inst_stb = 1'b0;
      pix_stb  = 1'b0;
      hi_ld    = 1'b0;
      if (done) begin
         if (!frame[8]) begin
            inst_stb = 1'b1;
            state_nx = frame[7:0] == CMD_RAMWR ? RX_PIX_HI : RX_CMD;
         end else if (state == RX_PIX_HI) begin
            hi_ld    = 1'b1;
            state_nx = RX_PIX_LO;
         end else if (state == RX_PIX_LO) begin
            pix_stb  = 1'b1;
            state_nx = RX_PIX_HI;
         end
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= RX_CMD;
         sck_d           <= 1'b0;
         cs_d            <= 1'b1;
         bit_cnt         <= 4'd0;
         shift_reg       <= 8'd0;
         hi_byte         <= 8'd0;
         o_inst_data     <= 8'd0;
         o_inst_en_pls   <= 1'b0;
         o_pixel_data    <= '0;
         o_pixel_en_pls  <= 1'b0;
         o_frame_err_pls <= 1'b0;
      end else begin
         state           <= state_nx;
         sck_d           <= sck_s;
         cs_d            <= cs_s;
         o_inst_en_pls   <= inst_stb;
         o_pixel_en_pls  <= pix_stb;
         o_frame_err_pls <= err_stb;
         if (inst_stb) o_inst_data <= frame[7:0];
         if (pix_stb)  o_pixel_data <= {hi_byte, frame[7:0]};
         if (hi_ld)    hi_byte <= frame[7:0];
         // a CS edge in the same cycle as an SCK edge drops that bit
         if (cs_fall || cs_rise) bit_cnt <= 4'd0;
         else if (bit_en) begin
            shift_reg <= frame[7:0];
            bit_cnt   <= bit_cnt == LAST_BIT ? 4'd0 : bit_cnt + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_spi_lcd_frame_rx.sv
// tb_spi_lcd_frame_rx: directed table, corner sequences and random frames against a frame-level model
module tb_spi_lcd_frame_rx;
   import lcd_ctrl_pkg::*;
   localparam time HALF = 40ns;
   logic clk = 1'b0, rst = 1'b1, sck = 1'b0, cs = 1'b1, mosi = 1'b0;
   logic [7:0] inst_data;
   logic [15:0] pix_data;
   logic inst_en, pix_en, err;
   int checks = 0, failures = 0;
   int n_inst = 0, n_pix = 0, n_err = 0;
   logic p_inst = 1'b0, p_pix = 1'b0, p_err = 1'b0;
   bit m_pix = 1'b0, m_phase = 1'b0;
   logic [7:0] m_hi = 8'd0, e_inst_d = 8'd0;
   logic [15:0] e_pix_d = 16'd0;
   int e_inst = 0, e_pix = 0, e_err = 0;
   typedef struct {
      bit cs_gap;
      bit dcx;
      logic [7:0] b;
      int d_inst;
      int d_pix;
      logic [7:0] x_inst;
      logic [15:0] x_pix;
   } vec_t;
   vec_t vecs[12];

   always #5ns clk = ~clk;

   spi_lcd_frame_rx dut (
      .i_clk(clk), .i_rst(rst), .i_spi_clk(sck), .i_spi_cs(cs), .i_spi_mosi(mosi),
      .o_inst_data(inst_data), .o_inst_en_pls(inst_en), .o_pixel_data(pix_data),
      .o_pixel_en_pls(pix_en), .o_frame_err_pls(err));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // strobe bookkeeping plus pulse-width and exclusivity checks on every strobe cycle
   always @(negedge clk) begin
      if (inst_en) begin n_inst++; check("inst_wide", {31'd0, p_inst}, 0); end
      if (pix_en) begin n_pix++; check("pix_wide", {31'd0, p_pix}, 0); end
      if (err) begin n_err++; check("err_wide", {31'd0, p_err}, 0); end
      if (inst_en || pix_en) check("strobe_excl", {31'd0, inst_en & pix_en}, 0);
      p_inst = inst_en;
      p_pix  = pix_en;
      p_err  = err;
   end

   task automatic m_frame(input bit dcx, input logic [7:0] b);
      if (!dcx) begin
         e_inst++;
         e_inst_d = b;
         m_pix    = (b == CMD_RAMWR);
         m_phase  = 1'b0;
      end else if (m_pix) begin
         if (!m_phase) m_hi = b;
         else begin
            e_pix++;
            e_pix_d = {m_hi, b};
         end
         m_phase = ~m_phase;
      end
   endtask

   task automatic cs_low();
      if (cs) begin cs = 1'b0; #HALF; end
   endtask

   task automatic cs_high();
      #HALF;
      cs = 1'b1;
      #HALF;
   endtask

   task automatic send_bits(input logic [8:0] f, input int n);
      for (int i = 8; i > 8 - n; i--) begin
         mosi = f[i];
         #HALF;
         sck = 1'b1;
         #HALF;
         sck = 1'b0;
      end
   endtask

   task automatic send_frame(input bit dcx, input logic [7:0] b);
      cs_low();
      send_bits({dcx, b}, 9);
      m_frame(dcx, b);
   endtask

   task automatic verify(input string tag);
      repeat (12) @(negedge clk);
      check({tag, "_inst_cnt"}, n_inst, e_inst);
      check({tag, "_pix_cnt"}, n_pix, e_pix);
      check({tag, "_err_cnt"}, n_err, e_err);
      check({tag, "_inst_data"}, {24'd0, inst_data}, {24'd0, e_inst_d});
      check({tag, "_pix_data"}, {16'd0, pix_data}, {16'd0, e_pix_d});
   endtask

   initial begin
      int bi, bp, be;
      vecs[0]  = '{0, 0, 8'h2C, 1, 0, 8'h2C, 16'h0000};
      vecs[1]  = '{0, 1, 8'hF8, 0, 0, 8'h2C, 16'h0000};
      vecs[2]  = '{0, 1, 8'h1F, 0, 1, 8'h2C, 16'hF81F};
      vecs[3]  = '{0, 0, 8'h2C, 1, 0, 8'h2C, 16'hF81F};
      vecs[4]  = '{0, 1, 8'h11, 0, 0, 8'h2C, 16'hF81F};
      vecs[5]  = '{0, 1, 8'h22, 0, 1, 8'h2C, 16'h1122};
      vecs[6]  = '{0, 1, 8'h33, 0, 0, 8'h2C, 16'h1122};
      vecs[7]  = '{0, 0, 8'h29, 1, 0, 8'h29, 16'h1122};
      vecs[8]  = '{0, 1, 8'h44, 0, 0, 8'h29, 16'h1122};
      vecs[9]  = '{0, 0, 8'h2C, 1, 0, 8'h2C, 16'h1122};
      vecs[10] = '{1, 1, 8'h12, 0, 0, 8'h2C, 16'h1122};
      vecs[11] = '{1, 1, 8'h34, 0, 1, 8'h2C, 16'h1234};
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", {7'd0, inst_data, inst_en, pix_data, pix_en, err}, 0);
      foreach (vecs[k]) begin
         bi = n_inst; bp = n_pix; be = n_err;
         if (vecs[k].cs_gap) cs_high();
         send_frame(vecs[k].dcx, vecs[k].b);
         repeat (12) @(negedge clk);
         check($sformatf("vec%0d_inst_cnt", k), n_inst - bi, vecs[k].d_inst);
         check($sformatf("vec%0d_pix_cnt", k), n_pix - bp, vecs[k].d_pix);
         check($sformatf("vec%0d_err_cnt", k), n_err - be, 0);
         check($sformatf("vec%0d_inst_data", k), {24'd0, inst_data}, {24'd0, vecs[k].x_inst});
         check($sformatf("vec%0d_pix_data", k), {16'd0, pix_data}, {16'd0, vecs[k].x_pix});
      end
      send_frame(1'b0, CMD_NOP);
      verify("nop");
      send_bits(9'h1A5, 5);
      cs_high();
      check("partial_err", n_err - e_err, 1);
      e_err++;
      send_frame(1'b1, 8'hAA);
      verify("after_partial");
      cs_high();
      for (int i = 0; i < 9; i++) begin
         mosi = i[0];
         #HALF; sck = 1'b1; #HALF; sck = 1'b0;
      end
      verify("sck_cs_high");
      send_frame(1'b0, CMD_RAMWR);
      send_frame(1'b1, 8'h5A);
      send_bits(9'h1C3, 4);
      rst = 1'b1;
      #HALF; sck = 1'b1; #HALF; sck = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midreset_outputs", {7'd0, inst_data, inst_en, pix_data, pix_en, err}, 0);
      n_inst = 0; n_pix = 0; n_err = 0;
      e_inst = 0; e_pix = 0; e_err = 0;
      e_inst_d = 8'd0; e_pix_d = 16'd0;
      m_pix = 1'b0; m_phase = 1'b0;
      cs_high();
      send_frame(1'b1, 8'h77);
      send_frame(1'b1, 8'h88);
      verify("post_reset");
      for (int i = 0; i < 60; i++) begin
         int r;
         logic [7:0] b;
         r = $urandom_range(0, 9);
         b = 8'($urandom);
         if (r == 0) begin
            cs_low();
            send_bits(9'($urandom), $urandom_range(1, 8));
            cs_high();
            e_err++;
         end else if (r == 1) begin
            cs_high();
            cs_low();
         end else if (r <= 3) begin
            case ($urandom_range(0, 4))
               0, 1: b = CMD_RAMWR;
               2: b = CMD_NOP;
               3: b = CMD_DISPON;
               default: ;
            endcase
            send_frame(1'b0, b);
         end else send_frame(1'b1, b);
         verify($sformatf("rnd%0d", i));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
